// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with the architectural HI/LO
// registers for the pipelined MIPS core.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high reset
//   start  in   1   issue strobe from EX, honoured only while busy=0
//   op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 see below
//   a      in  32   rs operand (dividend / multiplicand / mthi-mtlo data)
//   b      in  32   rt operand (divisor / multiplier)
//   busy   out  1   high while a mult/div is in flight
//   hi     out 32   HI register
//   lo     out 32   LO register
//
// Optional feature: define MDU_MADD_EN to enable op 6 = madd and op 7 = maddu
// (accumulate into {hi,lo}, MULT_CYCLES latency). Without it, ops 6/7 are ignored.
//
// The result is computed combinationally from the operands latched at accept
// and written into {hi,lo} on the edge where the countdown expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q, b_q;
    logic [2:0]    op_q;

    // Decode of the incoming op: multi-cycle class and which latency to load.
    logic is_long, is_div;
    always_comb begin
        is_long = 1'b0;
        is_div  = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: is_long = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_long = 1'b1;
                is_div  = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: is_long = 1'b1;
`endif
            default: ;
        endcase
    end

    // Products: the signed one is taken as a 64x64 product of sign-extended
    // operands; the low 64 bits equal the two's-complement signed product.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Unsigned divide with the zero divisor replaced so no X/undefined value
    // is ever produced; the zero case is muxed in separately.
    logic        b_zero;
    logic [31:0] b_safe, uq, ur;
    assign b_zero = (b_q == 32'd0);
    assign b_safe = b_zero ? 32'd1 : b_q;
    assign uq     = a_q / b_safe;
    assign ur     = a_q % b_safe;

    // Signed divide done on magnitudes so truncation toward zero and the
    // remainder sign (follows dividend) are explicit, not simulator-defined.
    logic        ovf;
    logic [31:0] ma, mb, mq, mr, sq, sr;
    assign ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign ma  = a_q[31] ? (32'd0 - a_q) : a_q;
    assign mb  = b_zero ? 32'd1 : (b_q[31] ? (32'd0 - b_q) : b_q);
    assign mq  = ma / mb;
    assign mr  = ma % mb;
    assign sq  = (a_q[31] ^ b_q[31]) ? (32'd0 - mq) : mq;
    assign sr  = a_q[31] ? (32'd0 - mr) : mr;

    logic [63:0] res;
    always_comb begin
        res = {hi, lo};
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (b_zero)   res = {a_q, 32'hFFFF_FFFF};
                else if (ovf) res = {32'd0, 32'h8000_0000};
                else          res = {sr, sq};
            end
            OP_DIVU: res = b_zero ? {a_q, 32'hFFFF_FFFF} : {ur, uq};
`ifdef MDU_MADD_EN
            // Accumulates onto {hi,lo} as present at the completing edge.
            OP_MADD:  res = {hi, lo} + prod_s;
            OP_MADDU: res = {hi, lo} + prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_long) begin
                            a_q   <= a;
                            b_q   <= b;
                            op_q  <= op;
                            cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state <= S_RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    // Last busy cycle: drop busy and write the result together.
                    if (cnt == CW'(1)) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        {hi, lo} <= res;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);

endmodule
